alu_cmd_ctrl: RTL and testbench
===============================

# alu_cmd_ctrl

Command sequencer that sits between the UART receive/transmit path and the ALU. It collects a command frame byte by byte from the UART RX parallel interface and latches the operands. It then drives a single-cycle ALU enable with the function code, waits for the ALU result, and returns the 16-bit result to the UART TX path as two bytes.

## Interface
- DATA_WIDTH, 8, UART byte width and ALU operand width
- FUN_WIDTH, 4, ALU function code width; the upper 2 bits select the unit (arith/logic/cmp/shift)
- TIMEOUT, 15, maximum cycles to wait for ALU OUT_VALID before aborting
- CMD_ALU_OP, 8'hCC, opcode for a frame carrying new operands: opcode, A, B, FUN
- CMD_ALU_NOP, 8'hDD, opcode for a frame that reuses the stored operands: opcode, FUN

- CLK  in  1  system clock; all state changes on the rising edge
- RST  in  1  asynchronous, active-high reset
- RX_P_DATA  in  DATA_WIDTH  received byte
- RX_D_VLD  in  1  single-cycle strobe; RX_P_DATA is valid in this cycle
- ALU_OUT  in  2*DATA_WIDTH  ALU result
- OUT_VALID  in  1  ALU result valid strobe
- TX_READY  in  1  TX can accept a byte
- OP_A  out  DATA_WIDTH  latched operand A
- OP_B  out  DATA_WIDTH  latched operand B
- ALU_FUN  out  FUN_WIDTH  latched function code
- ALU_EN  out  1  ALU enable; one-cycle pulse
- TX_P_DATA  out  DATA_WIDTH  byte to transmit
- TX_D_VLD  out  1  TX byte valid; held until accepted
- ERR  out  1  one-cycle pulse on timeout or dropped byte

## Operation
- States: IDLE, GET_A, GET_B, GET_FUN, RUN, WAIT_RES, TX_LSB, TX_MSB.
- IDLE, RX_D_VLD with CMD_ALU_OP: go to GET_A.
- IDLE, RX_D_VLD with CMD_ALU_NOP: go to GET_FUN.
- IDLE, RX_D_VLD with any other byte: ignored; no ERR.
- GET_A: on RX_D_VLD, latch OP_A and go to GET_B.
- GET_B: on RX_D_VLD, latch OP_B and go to GET_FUN.
- GET_FUN: on RX_D_VLD, latch ALU_FUN from RX_P_DATA[FUN_WIDTH-1:0] and go to RUN. Upper bits of that byte are ignored.
- RUN: ALU_EN=1 for exactly this one cycle, then go to WAIT_RES. Timeout counter clears on entry to WAIT_RES.
- WAIT_RES: on OUT_VALID, capture ALU_OUT into the result register and go to TX_LSB.
  - If the counter reaches TIMEOUT without OUT_VALID: pulse ERR, go to IDLE, send nothing.
  - OUT_VALID in the same cycle as the timeout: the result wins and no ERR is raised.
- TX_LSB: TX_P_DATA=result[7:0] and TX_D_VLD=1. On the cycle with TX_D_VLD && TX_READY, go to TX_MSB.
- TX_MSB: same handshake with result[15:8], then go to IDLE.
- RX_D_VLD in RUN, WAIT_RES, TX_LSB or TX_MSB: byte dropped, ERR pulsed for one cycle, state unchanged.
- OP_A, OP_B and ALU_FUN hold their values across frames, so CMD_ALU_NOP uses the last operands.
- OUT_VALID outside WAIT_RES is ignored.
- RST asserted mid-frame or mid-transmit: immediate return to IDLE. A partial TX byte is abandoned.

## Timing
- Reset values: all outputs 0, state IDLE, result register 0, timeout counter 0.
- Every output is registered; no combinational path from any input to any output.
- ALU_EN rises on the clock edge after the FUN byte strobe.
- ALU_OUT is sampled in the same cycle OUT_VALID is high.
- TX_D_VLD rises on the edge after OUT_VALID is captured.
- TX_P_DATA is stable while TX_D_VLD=1 and TX_READY=0.
- TX_D_VLD drops on the edge after the MSB handshake; there is no bubble between the LSB and MSB bytes when TX_READY stays high.
- Minimum latency, FUN strobe to first TX_D_VLD, with OUT_VALID on the cycle after ALU_EN: 3 cycles.
- A new RX frame is accepted from the cycle the state returns to IDLE.

## Test plan
- Frame CC,05,03,00; ALU returns 0x0008 one cycle after ALU_EN; TX_READY=1 -> OP_A=05, OP_B=03, ALU_FUN=0, one ALU_EN pulse, TX bytes 08 then 00.
- After that frame, send DD,01 with ALU returning 0x0002 -> no change on OP_A/OP_B, ALU_FUN=1, TX bytes 02 then 00.
- OUT_VALID never arrives -> ERR pulses exactly TIMEOUT+1 cycles after ALU_EN, no TX_D_VLD, state IDLE; a following CC frame completes normally.
- ALU result 0xABCD with TX_READY low for 4 cycles on each byte -> TX_P_DATA holds CD then AB, and each byte is accepted exactly once.
- Byte 0x77 in IDLE -> no state change and no ERR. An RX strobe during TX_LSB -> ERR pulse, and the transmitted bytes are unaffected.
- RST asserted while in GET_B -> all outputs 0 immediately. After release, frame CC,01,01,00 yields TX bytes 02, 00.

Source files
------------

// File: rtl/alu_cmd_ctrl.sv
// UART-to-ALU command sequencer: parses CC/DD frames, fires one ALU_EN pulse,
// waits (bounded) for the result and streams it back LSB-first over the TX handshake.
module alu_cmd_ctrl #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    FUN_WIDTH   = 4,
    parameter int                    TIMEOUT     = 15,
    parameter logic [DATA_WIDTH-1:0] CMD_ALU_OP  = 8'hCC,
    parameter logic [DATA_WIDTH-1:0] CMD_ALU_NOP = 8'hDD
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
    input  logic                    RX_D_VLD,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    OUT_VALID,
    input  logic                    TX_READY,
    output logic [DATA_WIDTH-1:0]   OP_A,
    output logic [DATA_WIDTH-1:0]   OP_B,
    output logic [FUN_WIDTH-1:0]    ALU_FUN,
    output logic                    ALU_EN,
    output logic [DATA_WIDTH-1:0]   TX_P_DATA,
    output logic                    TX_D_VLD,
    output logic                    ERR
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_GET_A, S_GET_B, S_GET_FUN, S_RUN, S_WAIT_RES, S_TX_LSB, S_TX_MSB
    } state_t;

    state_t                    r_state, w_state_nxt;
    logic [DATA_WIDTH-1:0]     r_op_a, w_op_a_nxt;
    logic [DATA_WIDTH-1:0]     r_op_b, w_op_b_nxt;
    logic [FUN_WIDTH-1:0]      r_fun, w_fun_nxt;
    logic                      r_alu_en, w_alu_en_nxt;
    logic [DATA_WIDTH-1:0]     r_tx_data, w_tx_data_nxt;
    logic                      r_tx_vld, w_tx_vld_nxt;
    logic                      r_err, w_err_nxt;
    logic [2*DATA_WIDTH-1:0]   r_result, w_result_nxt;
    logic [CNT_W-1:0]          r_cnt, w_cnt_nxt;

    logic w_tx_acc;
    logic w_timeout;
    logic w_rx_drop;

    assign w_tx_acc  = r_tx_vld && TX_READY;
    assign w_timeout = (r_state == S_WAIT_RES) && (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_rx_drop = RX_D_VLD && ((r_state == S_RUN) || (r_state == S_WAIT_RES) ||
                                    (r_state == S_TX_LSB) || (r_state == S_TX_MSB));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (RX_D_VLD && (RX_P_DATA == CMD_ALU_OP))       w_state_nxt = S_GET_A;
                else if (RX_D_VLD && (RX_P_DATA == CMD_ALU_NOP)) w_state_nxt = S_GET_FUN;
            end
            S_GET_A:    if (RX_D_VLD) w_state_nxt = S_GET_B;
            S_GET_B:    if (RX_D_VLD) w_state_nxt = S_GET_FUN;
            S_GET_FUN:  if (RX_D_VLD) w_state_nxt = S_RUN;
            S_RUN:      w_state_nxt = S_WAIT_RES;
            // A result arriving on the timeout cycle still takes priority.
            S_WAIT_RES: begin
                if (OUT_VALID)      w_state_nxt = S_TX_LSB;
                else if (w_timeout) w_state_nxt = S_IDLE;
            end
            S_TX_LSB:   if (w_tx_acc) w_state_nxt = S_TX_MSB;
            S_TX_MSB:   if (w_tx_acc) w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // Next values for the output registers; all ports are driven straight from flops.
    always_comb begin
        w_op_a_nxt    = r_op_a;
        w_op_b_nxt    = r_op_b;
        w_fun_nxt     = r_fun;
        w_alu_en_nxt  = 1'b0;
        w_tx_data_nxt = r_tx_data;
        w_tx_vld_nxt  = r_tx_vld;
        w_err_nxt     = w_rx_drop;
        w_result_nxt  = r_result;
        w_cnt_nxt     = r_cnt;
        case (r_state)
            S_GET_A: if (RX_D_VLD) w_op_a_nxt = RX_P_DATA;
            S_GET_B: if (RX_D_VLD) w_op_b_nxt = RX_P_DATA;
            S_GET_FUN: begin
                if (RX_D_VLD) begin
                    w_fun_nxt    = RX_P_DATA[FUN_WIDTH-1:0];
                    w_alu_en_nxt = 1'b1;
                end
            end
            S_RUN: w_cnt_nxt = '0;
            S_WAIT_RES: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (OUT_VALID) begin
                    w_result_nxt  = ALU_OUT;
                    w_tx_data_nxt = ALU_OUT[DATA_WIDTH-1:0];
                    w_tx_vld_nxt  = 1'b1;
                end else if (w_timeout) begin
                    w_err_nxt = 1'b1;
                end
            end
            S_TX_LSB: w_tx_data_nxt = w_tx_acc ? r_result[2*DATA_WIDTH-1:DATA_WIDTH]
                                               : r_result[DATA_WIDTH-1:0];
            S_TX_MSB: if (w_tx_acc) w_tx_vld_nxt = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_fun     <= '0;
            r_alu_en  <= 1'b0;
            r_tx_data <= '0;
            r_tx_vld  <= 1'b0;
            r_err     <= 1'b0;
            r_result  <= '0;
            r_cnt     <= '0;
        end else begin
            r_op_a    <= w_op_a_nxt;
            r_op_b    <= w_op_b_nxt;
            r_fun     <= w_fun_nxt;
            r_alu_en  <= w_alu_en_nxt;
            r_tx_data <= w_tx_data_nxt;
            r_tx_vld  <= w_tx_vld_nxt;
            r_err     <= w_err_nxt;
            r_result  <= w_result_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    assign OP_A      = r_op_a;
    assign OP_B      = r_op_b;
    assign ALU_FUN   = r_fun;
    assign ALU_EN    = r_alu_en;
    assign TX_P_DATA = r_tx_data;
    assign TX_D_VLD  = r_tx_vld;
    assign ERR       = r_err;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Bench for alu_cmd_ctrl: directed frames from the test plan plus randomized frames,
// checked against a frame-level model (stored operands, expected TX byte sequence).
module tb_alu_cmd_ctrl;

    localparam int         TO    = 15;
    localparam logic [7:0] C_OP  = 8'hCC;
    localparam logic [7:0] C_NOP = 8'hDD;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  RX_P_DATA = 8'h00;
    logic        RX_D_VLD = 1'b0;
    logic [15:0] ALU_OUT = 16'h0000;
    logic        OUT_VALID = 1'b0;
    logic        TX_READY = 1'b0;
    logic [7:0]  OP_A, OP_B, TX_P_DATA;
    logic [3:0]  ALU_FUN;
    logic        ALU_EN, TX_D_VLD, ERR;

    int total = 0;
    int bad   = 0;

    logic [7:0] m_a   = 8'h00;
    logic [7:0] m_b   = 8'h00;
    logic [3:0] m_fun = 4'h0;

    alu_cmd_ctrl #(.DATA_WIDTH(8), .FUN_WIDTH(4), .TIMEOUT(TO),
                   .CMD_ALU_OP(C_OP), .CMD_ALU_NOP(C_NOP)) dut (
        .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID), .TX_READY(TX_READY),
        .OP_A(OP_A), .OP_B(OP_B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        step();
        RX_D_VLD  = 1'b0;
        RX_P_DATA = 8'($urandom);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_op_a"},  OP_A, 0);
        chk({tag, "_op_b"},  OP_B, 0);
        chk({tag, "_fun"},   ALU_FUN, 0);
        chk({tag, "_en"},    ALU_EN, 0);
        chk({tag, "_txd"},   TX_P_DATA, 0);
        chk({tag, "_txv"},   TX_D_VLD, 0);
        chk({tag, "_err"},   ERR, 0);
    endtask

    // One complete frame: command, operands, ALU response after dly wait cycles,
    // then the TX handshake with stall cycles before each accept.
    task automatic run_frame(input bit is_op, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] fb, input logic [15:0] res, input int dly,
                             input int stall, input bit inj_rx, input bit stray_ov);
        logic [7:0] got[$];
        logic [7:0] exp_b;
        int cyc;
        int st;
        if (is_op) begin
            m_a = a;
            m_b = b;
            send_byte(C_OP);
            send_byte(a);
            send_byte(b);
        end else begin
            send_byte(C_NOP);
        end
        m_fun = fb[3:0];
        send_byte(fb);
        chk("alu_en_rise", ALU_EN, 1);
        chk("op_a", OP_A, m_a);
        chk("op_b", OP_B, m_b);
        chk("alu_fun", ALU_FUN, m_fun);
        ALU_OUT = 16'($urandom);
        step();
        chk("alu_en_fall", ALU_EN, 0);
        for (int i = 0; i < dly; i++) begin
            ALU_OUT = 16'($urandom);
            step();
            chk("wait_no_tx", TX_D_VLD, 0);
            chk("wait_no_err", ERR, 0);
        end
        ALU_OUT   = res;
        OUT_VALID = 1'b1;
        step();
        OUT_VALID = 1'b0;
        ALU_OUT   = 16'($urandom);
        cyc = 0;
        st  = 0;
        while (got.size() < 2 && cyc < 60) begin
            exp_b = (got.size() == 0) ? res[7:0] : res[15:8];
            chk("tx_vld", TX_D_VLD, 1);
            chk("tx_data", TX_P_DATA, exp_b);
            chk("tx_err", ERR, inj_rx && cyc == 1);
            TX_READY = (st >= stall);
            if (inj_rx && cyc == 0) begin
                RX_D_VLD  = 1'b1;
                RX_P_DATA = C_OP;
            end
            if (stray_ov) begin
                OUT_VALID = 1'($urandom_range(0, 1));
                ALU_OUT   = 16'($urandom);
            end
            if (TX_READY && TX_D_VLD) begin
                got.push_back(TX_P_DATA);
                st = 0;
            end else begin
                st++;
            end
            step();
            RX_D_VLD  = 1'b0;
            OUT_VALID = 1'b0;
            TX_READY  = 1'b0;
            cyc++;
        end
        chk("tx_count", got.size(), 2);
        if (stall == 0) chk("tx_no_bubble", cyc, 2);
        chk("tx_drop", TX_D_VLD, 0);
        chk("tx_end_err", ERR, 0);
    endtask

    initial begin
        #2 RST = 1'b1;
        #1 chk_all_zero("reset");
        step();
        RST = 1'b0;
        step();

        // Test plan frames: add 5+3, then NOP with sub reusing operands.
        run_frame(1, 8'h05, 8'h03, 8'h00, 16'h0008, 0, 0, 0, 0);
        run_frame(0, 8'h00, 8'h00, 8'h01, 16'h0002, 0, 0, 0, 0);

        // Timeout: ERR exactly TO+1 cycles after ALU_EN, nothing transmitted.
        send_byte(C_NOP);
        m_fun = 4'h2;
        send_byte(8'hF2);
        chk("to_alu_en", ALU_EN, 1);
        chk("to_fun_upper_ignored", ALU_FUN, m_fun);
        for (int k = 1; k <= TO + 2; k++) begin
            ALU_OUT = 16'($urandom);
            step();
            chk("to_err", ERR, k == TO + 1);
            chk("to_no_tx", TX_D_VLD, 0);
        end
        run_frame(1, 8'h21, 8'h42, 8'h05, 16'h1357, 1, 0, 0, 0);

        // Stalled TX of 0xABCD.
        run_frame(1, 8'h12, 8'h34, 8'h03, 16'hABCD, 2, 4, 0, 0);

        // Unknown bytes in IDLE are silently ignored.
        send_byte(8'h77);
        chk("idle_77_err", ERR, 0);
        chk("idle_77_en", ALU_EN, 0);
        send_byte(8'h00);
        chk("idle_00_err", ERR, 0);
        run_frame(1, 8'h9A, 8'hBC, 8'h07, 16'h5A3C, 0, 1, 1, 0);

        // Result on the very cycle the timeout would fire.
        run_frame(0, 8'h00, 8'h00, 8'h0C, 16'hFEDC, TO - 1, 0, 0, 0);

        for (int i = 0; i < 10; i++) begin
            run_frame((i == 0) || ($urandom_range(0, 1) == 1), 8'($urandom), 8'($urandom),
                      8'($urandom), 16'($urandom), $urandom_range(0, TO - 1),
                      $urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'b1);
        end

        // Reset while collecting operand B.
        send_byte(C_OP);
        send_byte(8'h11);
        chk("pre_rst_op_a", OP_A, 8'h11);
        RST = 1'b1;
        #1 chk_all_zero("mid_rst");
        m_a = 8'h00;
        m_b = 8'h00;
        m_fun = 4'h0;
        step();
        RST = 1'b0;
        step();
        run_frame(1, 8'h01, 8'h01, 8'h00, 16'h0002, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
